fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_incr.sv | 11 +
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] PC_INCR = 32'd4;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    // Instruction addresses are word aligned; low bits of any source are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-PC adder: pc + 4, wrapping modulo 2^32.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc4
);

    assign pc4 = pc + PC_INCR;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory request, picks the next PC and
// owns the IF/ID register, a one-word hold buffer and a pending-redirect target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
);

    state_t      state, state_nxt;
    logic [31:0] pc4;
    logic [31:0] pc_raw;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] hold_instr, hold_pc4;
    logic [31:0] drain_target;

    logic        hold_load;
    logic        target_load;
    logic        if_id_load_mem;
    logic        if_id_load_hold;
    logic        if_id_clear;

    pc_incr u_pc_incr (
        .pc  (pc_in),
        .pc4 (pc4)
    );

    always_comb begin
        redirect        = branch_taken | jump;
        redirect_target = branch_taken ? branch_target : jump_target;

        state_nxt       = state;
        pc_raw          = pc_in;
        imem_req        = 1'b0;
        imem_addr       = pc_in;
        hold_load       = 1'b0;
        target_load     = 1'b0;
        if_id_load_mem  = 1'b0;
        if_id_load_hold = 1'b0;
        if_id_clear     = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    pc_raw      = redirect_target;
                    if_id_clear = 1'b1;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if_id_clear = 1'b1;
                    if (imem_ack) begin
                        pc_raw = redirect_target;
                    end else begin
                        // Request still in flight: keep the address, remember where to go.
                        target_load = 1'b1;
                        state_nxt   = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        if_id_load_mem = 1'b1;
                        pc_raw         = pc4;
                    end else begin
                        hold_load = 1'b1;
                        state_nxt = HELD;
                    end
                end else if (!stall) begin
                    if_id_clear = 1'b1;
                end
            end
            HELD: begin
                if (redirect) begin
                    pc_raw      = redirect_target;
                    if_id_clear = 1'b1;
                    state_nxt   = FETCH;
                end else if (!stall) begin
                    if_id_load_hold = 1'b1;
                    pc_raw          = pc4;
                    state_nxt       = FETCH;
                end
            end
            DRAIN: begin
                imem_req    = 1'b1;
                if_id_clear = 1'b1;
                if (redirect) begin
                    target_load = 1'b1;
                end
                if (imem_ack) begin
                    pc_raw    = redirect ? redirect_target : drain_target;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (reset) begin
            pc_raw   = RESET_PC;
            imem_req = 1'b0;
        end

        pc_next = align_pc(pc_raw);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_instr   <= NOP;
            hold_pc4     <= 32'h0;
            drain_target <= 32'h0;
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP;
            if_id_pc4    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_instr <= imem_rdata;
                hold_pc4   <= pc4;
            end
            if (target_load) begin
                drain_target <= redirect_target;
            end
            if (if_id_clear) begin
                if_id_valid <= 1'b0;
            end else if (if_id_load_mem) begin
                if_id_valid <= 1'b1;
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc4;
            end else if (if_id_load_hold) begin
                if_id_valid <= 1'b1;
                if_id_instr <= hold_instr;
                if_id_pc4   <= hold_pc4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit with a queue-based scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } item_t;
    item_t exp_q[$];

    // Reference model: what the fetch stage is doing, in plain terms.
    bit          m_idle  = 1'b1;   // one dead cycle after reset
    bit          m_held  = 1'b0;   // a fetched word is parked
    bit          m_drain = 1'b0;   // waiting out a request whose data is unwanted
    bit          m_valid = 1'b0;   // IF/ID holds a live instruction
    logic [31:0] m_held_instr = 32'h0;
    logic [31:0] m_held_pc4   = 32'h0;
    logic [31:0] m_drain_tgt  = 32'h0;
    logic [31:0] m_pc_reg     = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drop the live IF/ID item; if decode is stalled it was never taken.
    task automatic flush(input bit stl);
        if (m_valid && stl && exp_q.size() > 0) void'(exp_q.pop_back());
        m_valid = 1'b0;
    endtask

    task automatic step(input bit rst, input bit ack, input logic [31:0] rdata, input bit stl,
                        input bit br, input logic [31:0] bt, input bit jp, input logic [31:0] jt);
        logic [31:0] nxt;
        logic [31:0] tgt;
        logic [31:0] seq;
        bit          req;
        bit          redirect;
        @(posedge clk);
        #2;
        reset = rst; pc_in = m_pc_reg; imem_ack = ack; imem_rdata = rdata; stall = stl;
        branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
        #1;
        check32("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});

        redirect = br | jp;
        tgt      = br ? bt : jt;
        seq      = pc_in + 32'd4;
        nxt      = pc_in;
        req      = 1'b0;
        if (rst) begin
            nxt = 32'h0;
            exp_q.delete();
            m_valid = 1'b0; m_idle = 1'b1; m_held = 1'b0; m_drain = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            if (redirect) begin nxt = tgt; flush(stl); end
        end else if (m_held) begin
            if (redirect) begin
                nxt = tgt; flush(stl); m_held = 1'b0;
            end else if (!stl) begin
                nxt = seq; exp_q.push_back('{m_held_instr, m_held_pc4});
                m_valid = 1'b1; m_held = 1'b0;
            end
        end else if (m_drain) begin
            req = 1'b1;
            if (redirect) m_drain_tgt = tgt;
            if (ack) begin nxt = m_drain_tgt; m_drain = 1'b0; end
        end else begin
            req = 1'b1;
            if (redirect) begin
                flush(stl);
                if (ack) nxt = tgt;
                else begin m_drain = 1'b1; m_drain_tgt = tgt; end
            end else if (ack && !stl) begin
                exp_q.push_back('{rdata, seq}); m_valid = 1'b1; nxt = seq;
            end else if (ack) begin
                m_held = 1'b1; m_held_instr = rdata; m_held_pc4 = seq;
            end else if (!stl) begin
                m_valid = 1'b0;
            end
        end
        nxt = nxt & 32'hFFFF_FFFC;

        check32("pc_next", pc_next, nxt);
        check32("imem_req", {31'h0, imem_req}, {31'h0, req});
        if (req) check32("imem_addr", imem_addr, pc_in);
        m_pc_reg = nxt;
    endtask

    // Monitor: decode takes the IF/ID word at every edge where it is valid and not stalled.
    always @(negedge clk) begin
        item_t e;
        if (!reset && if_id_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr %h pc4 %h expected no valid word", if_id_instr, if_id_pc4);
            end else begin
                e = exp_q.pop_front();
                if (if_id_instr !== e.instr || if_id_pc4 !== e.pc4) begin
                    errors++;
                    $display("FAIL sb_word: got instr %h pc4 %h expected instr %h pc4 %h",
                             if_id_instr, if_id_pc4, e.instr, e.pc4);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and release
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check32("rst_pc_next", pc_next, 32'h0);
        check32("rst_req", {31'h0, imem_req}, 32'h0);
        check32("rst_valid", {31'h0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("rel_c1_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("rel_c2_req", {31'h0, imem_req}, 32'h1);

        // Streaming from 0x100
        step(0, 1, 32'h1111_1111, 0, 0, 0, 1, 32'h100);
        check32("jump_100", pc_next, 32'h100);
        step(0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        check32("stream_pc1", pc_next, 32'h104);
        step(0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        check32("stream_pc2", pc_next, 32'h108);
        check32("stream_instr", if_id_instr, 32'hAAAA_0001);
        check32("stream_pc4", if_id_pc4, 32'h104);
        step(0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        check32("stream_pc3", pc_next, 32'h10C);

        // Stall on ack, hold three cycles, then release
        step(0, 1, 32'h1234_5678, 1, 0, 0, 0, 0);
        check32("stall_ack_pc", pc_next, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 0, 0, 0);
            check32("stall_instr", if_id_instr, 32'hAAAA_0001);
            check32("stall_pc", pc_next, 32'h10C);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("release_pc", pc_next, 32'h110);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("release_instr", if_id_instr, 32'h1234_5678);
        check32("release_valid", {31'h0, if_id_valid}, 32'h1);

        // Branch then jump while a request is pending
        step(0, 0, 0, 0, 1, 32'h2000, 0, 0);
        check32("drain_addr0", imem_addr, 32'h110);
        step(0, 0, 0, 0, 0, 0, 1, 32'h3000);
        check32("drain_addr1", imem_addr, 32'h110);
        check32("drain_valid", {31'h0, if_id_valid}, 32'h0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        check32("drain_pc", pc_next, 32'h3000);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("drain_after_valid", {31'h0, if_id_valid}, 32'h0);

        // Priority, wrap and alignment
        step(0, 1, 0, 0, 1, 32'h4000, 1, 32'h5000);
        check32("prio_pc", pc_next, 32'h4000);
        step(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
        check32("wrap_pc", pc_next, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("wrap_pc4", if_id_pc4, 32'h0);
        step(0, 1, 0, 0, 1, 32'h1237, 0, 0);
        check32("align_pc", pc_next, 32'h1234);

        // Reset mid-request, late ack in IDLE
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        check32("late_ack_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check32("late_ack_valid", {31'h0, if_id_valid}, 32'h0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), $urandom,
                 ($urandom_range(0, 15) == 0), $urandom);
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
